// File: rtl/fram_pkg.sv
// rtl/fram_pkg.sv - shared opcodes, FSM states and write-protect helper for fram_access
package fram_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  typedef enum logic [3:0] {
    IDLE,
    WCOLLECT,
    WREN_CMD,
    CS_GAP,
    WR_HDR,
    WR_DATA,
    RD_HDR,
    RD_DATA,
    DONE
  } fram_state_t;

  // True when the wrapped range addr..addr+len-1 touches any address below top.
  // A range that runs past 16'hFFFF wraps through address 0, which is always protected.
  function automatic logic fram_prot_hit(input logic [15:0] addr,
                                         input logic [16:0] len,
                                         input logic [15:0] top);
    logic [16:0] last;
    last = {1'b0, addr} + len - 17'd1;
    return (len != 17'd0) && (top != 16'd0) && ((addr < top) || last[16]);
  endfunction

endpackage

// File: rtl/fram_spi_byte.sv
// rtl/fram_spi_byte.sv - one SPI mode-0 byte transfer, MSB first
module fram_spi_byte #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] im_tx,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic [7:0] om_rx,
  output logic       o_rx_valid,
  output logic       o_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic          r_busy;
  logic          r_sck;
  logic          r_mosi;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_div;
  logic          r_rx_valid;
  logic          r_done;

  // Half-period timer: SCK rises (sample MISO) and falls (next MOSI bit) every CLK_DIV cycles.
  // o_rx_valid marks the 8th rising edge; o_done marks the final falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_bit      <= 3'd0;
      r_div      <= '0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_tx   <= im_tx;
          r_mosi <= im_tx[7];
          r_bit  <= 3'd0;
          r_div  <= '0;
          r_sck  <= 1'b0;
        end
      end else if (r_div != DIV_LAST) begin
        r_div <= r_div + CW'(1);
      end else begin
        r_div <= '0;
        if (!r_sck) begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], i_miso};
          if (r_bit == 3'd7) r_rx_valid <= 1'b1;
        end else begin
          r_sck <= 1'b0;
          if (r_bit == 3'd7) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_bit  <= r_bit + 3'd1;
            r_tx   <= {r_tx[6:0], 1'b0};
            r_mosi <= r_tx[6];
          end
        end
      end
    end
  end

  assign o_sck      = r_sck;
  assign o_mosi     = r_mosi;
  assign om_rx      = r_rx;
  assign o_rx_valid = r_rx_valid;
  assign o_done     = r_done;

endmodule

// File: rtl/fram_access.sv
// rtl/fram_access.sv - SPI FRAM burst read/write controller; optional write protection via FRAM_WR_PROTECT_EN
module fram_access
  import fram_pkg::*;
#(
  parameter int          CLK_DIV    = 2,
  parameter int          WBUF_DEPTH = 64,
  parameter logic [15:0] PROT_TOP   = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fram_rden,
  input  logic        i_fram_wren,
  input  logic [15:0] im_fram_addr,
  input  logic [15:0] im_fram_wr_len,
  input  logic        i_fram_wr_dv,
  input  logic [7:0]  im_fram_wdata,
  output logic        o_fram_rd_dv,
  output logic [7:0]  om_fram_rdata,
  output logic        o_fram_rdy,
  output logic        o_fram_err,
  output logic        o_spi_csn,
  output logic        o_spi_sck,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int          AW          = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [16:0] BUF_LEN_MAX = 17'(WBUF_DEPTH);
  localparam logic [16:0] GAP_LAST    = 17'(2 * CLK_DIV - 1);

  fram_state_t r_state;
  logic [15:0] r_addr;
  logic [16:0] r_len;
  logic [16:0] r_cnt;
  logic [1:0]  r_hdr;
  logic        r_issued;
  logic        r_start;
  logic        r_rdy;
  logic        r_err;
  logic        r_csn;
  logic        r_rd_dv;
  logic [7:0]  r_rdata;
  logic [7:0]  r_buf_byte;
  logic [7:0]  r_wbuf [WBUF_DEPTH];

  logic [7:0]    w_tx;
  logic [7:0]    w_rx;
  logic          w_rx_valid;
  logic          w_done;
  logic          w_prot_hit;
  logic [AW-1:0] w_buf_idx;

  assign w_buf_idx = r_cnt[AW-1:0];

`ifdef FRAM_WR_PROTECT_EN
  assign w_prot_hit = fram_prot_hit(r_addr, r_len, PROT_TOP);
`else
  // Protection disabled: PROT_TOP is referenced only so the parameter stays visible.
  assign w_prot_hit = 1'b0 & (|PROT_TOP);
`endif

  fram_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi_byte (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_start),
    .im_tx      (w_tx),
    .i_miso     (i_spi_miso),
    .o_sck      (o_spi_sck),
    .o_mosi     (o_spi_mosi),
    .om_rx      (w_rx),
    .o_rx_valid (w_rx_valid),
    .o_done     (w_done)
  );

  // Write-burst RAM: filled in order during WCOLLECT, read synchronously by the byte counter.
  always_ff @(posedge clk) begin
    if (r_state == WCOLLECT && i_fram_wr_dv) r_wbuf[w_buf_idx] <= im_fram_wdata;
    r_buf_byte <= r_wbuf[w_buf_idx];
  end

  // Byte to shift out, picked by the current state and header position.
  always_comb begin
    w_tx = 8'h00;
    case (r_state)
      WREN_CMD: w_tx = OP_WREN;
      WR_HDR, RD_HDR: begin
        case (r_hdr)
          2'd0:    w_tx = (r_state == WR_HDR) ? OP_WRITE : OP_READ;
          2'd1:    w_tx = r_addr[15:8];
          default: w_tx = r_addr[7:0];
        endcase
      end
      WR_DATA: w_tx = r_buf_byte;
      default: w_tx = 8'h00;
    endcase
  end

  // Transaction FSM: each SPI byte is issued once (r_issued) and retired on the shifter's done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= 16'h0000;
      r_len    <= 17'd0;
      r_cnt    <= 17'd0;
      r_hdr    <= 2'd0;
      r_issued <= 1'b0;
      r_start  <= 1'b0;
      r_rdy    <= 1'b1;
      r_err    <= 1'b0;
      r_csn    <= 1'b1;
      r_rd_dv  <= 1'b0;
      r_rdata  <= 8'h00;
    end else begin
      r_err   <= 1'b0;
      r_rd_dv <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_fram_rden && i_fram_wren) begin
            r_err <= 1'b1;
          end else if (i_fram_rden || i_fram_wren) begin
            r_addr   <= im_fram_addr;
            r_len    <= {1'b0, im_fram_wr_len};
            r_rdy    <= 1'b0;
            r_cnt    <= 17'd0;
            r_hdr    <= 2'd0;
            r_issued <= 1'b0;
            if (im_fram_wr_len == 16'd0) begin
              r_state <= DONE;
            end else if (i_fram_rden) begin
              r_state <= RD_HDR;
            end else if ({1'b0, im_fram_wr_len} > BUF_LEN_MAX) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= WCOLLECT;
            end
          end
        end
        WCOLLECT: begin
          if (i_fram_wr_dv) begin
            if (r_cnt + 17'd1 == r_len) begin
              r_cnt <= 17'd0;
              if (w_prot_hit) begin
                r_err   <= 1'b1;
                r_state <= DONE;
              end else begin
                r_state <= WREN_CMD;
              end
            end else begin
              r_cnt <= r_cnt + 17'd1;
            end
          end
        end
        WREN_CMD: begin
          if (!r_issued) begin
            r_csn    <= 1'b0;
            r_start  <= 1'b1;
            r_issued <= 1'b1;
          end else if (w_done) begin
            r_csn    <= 1'b1;
            r_issued <= 1'b0;
            r_cnt    <= 17'd0;
            r_state  <= CS_GAP;
          end
        end
        CS_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= 17'd0;
            r_state <= WR_HDR;
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        WR_HDR, RD_HDR: begin
          if (!r_issued) begin
            r_csn    <= 1'b0;
            r_start  <= 1'b1;
            r_issued <= 1'b1;
          end else if (w_done) begin
            r_issued <= 1'b0;
            if (r_hdr == 2'd2) begin
              r_hdr   <= 2'd0;
              r_state <= (r_state == WR_HDR) ? WR_DATA : RD_DATA;
            end else begin
              r_hdr <= r_hdr + 2'd1;
            end
          end
        end
        WR_DATA, RD_DATA: begin
          if (r_state == RD_DATA && w_rx_valid) begin
            r_rd_dv <= 1'b1;
            r_rdata <= w_rx;
          end
          if (!r_issued) begin
            r_start  <= 1'b1;
            r_issued <= 1'b1;
          end else if (w_done) begin
            r_issued <= 1'b0;
            if (r_cnt + 17'd1 == r_len) r_state <= DONE;
            else                        r_cnt   <= r_cnt + 17'd1;
          end
        end
        DONE: begin
          r_csn   <= 1'b1;
          r_rdy   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_fram_rd_dv  = r_rd_dv;
  assign om_fram_rdata = r_rdata;
  assign o_fram_rdy    = r_rdy;
  assign o_fram_err    = r_err;
  assign o_spi_csn     = r_csn;

endmodule

// File: tb/tb_fram_access.sv
// tb/tb_fram_access.sv - scoreboard bench for fram_access with a behavioural SPI FRAM device
module tb_fram_access;

  localparam int WBUF = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_fram_rden = 1'b0;
  logic        i_fram_wren = 1'b0;
  logic [15:0] im_fram_addr = 16'h0;
  logic [15:0] im_fram_wr_len = 16'h0;
  logic        i_fram_wr_dv = 1'b0;
  logic [7:0]  im_fram_wdata = 8'h0;
  logic        i_spi_miso = 1'b0;
  logic        o_fram_rd_dv, o_fram_rdy, o_fram_err;
  logic [7:0]  om_fram_rdata;
  logic        o_spi_csn, o_spi_sck, o_spi_mosi;

  always #5 clk = ~clk;

  fram_access #(.CLK_DIV(2), .WBUF_DEPTH(WBUF), .PROT_TOP(16'h0100)) dut (
    .clk(clk), .rst(rst),
    .i_fram_rden(i_fram_rden), .i_fram_wren(i_fram_wren),
    .im_fram_addr(im_fram_addr), .im_fram_wr_len(im_fram_wr_len),
    .i_fram_wr_dv(i_fram_wr_dv), .im_fram_wdata(im_fram_wdata),
    .o_fram_rd_dv(o_fram_rd_dv), .om_fram_rdata(om_fram_rdata),
    .o_fram_rdy(o_fram_rdy), .o_fram_err(o_fram_err),
    .o_spi_csn(o_spi_csn), .o_spi_sck(o_spi_sck), .o_spi_mosi(o_spi_mosi),
    .i_spi_miso(i_spi_miso)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] dev_mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_mosi [$];
  logic [7:0] exp_rd [$];
  int         exp_flen [$];
  logic [7:0] wq [$];
  bit         quiet = 1'b0;
  int         frames_seen = 0;
  int         err_seen = 0;
  int         rd_seen = 0;

  logic       prev_sck = 1'b0;
  logic       prev_csn = 1'b1;
  int         fbits = 0;
  logic [7:0] sh = 8'h0;
  logic [7:0] fbytes [$];
  bit         wel = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic bit prot_hit(input logic [15:0] addr, input int len);
    bit hit = 1'b0;
`ifdef FRAM_WR_PROTECT_EN
    for (int i = 0; i < len; i++)
      if (((int'(addr) + i) % 65536) < 256) hit = 1'b1;
`endif
    return hit;
  endfunction

  function automatic void on_byte(input logic [7:0] b);
    logic [15:0] a;
    if (!quiet) begin
      if (exp_mosi.size() == 0) chk("mosi_extra_byte", {24'h0, b}, 32'hffff_ffff);
      else                      chk("mosi_byte", {24'h0, b}, {24'h0, exp_mosi.pop_front()});
    end
    if (fbytes[0] == 8'h02 && wel && fbytes.size() > 3) begin
      a = {fbytes[1], fbytes[2]} + 16'(fbytes.size() - 4);
      dev_mem[a] = b;
    end
  endfunction

  function automatic void on_frame_end();
    if (fbytes.size() == 1 && fbytes[0] == 8'h06) wel = 1'b1;
    else if (fbytes.size() > 0 && fbytes[0] == 8'h02) wel = 1'b0;
    if (!quiet) begin
      if (exp_flen.size() == 0) chk("frame_extra", fbytes.size(), 32'hffff_ffff);
      else                      chk("frame_len", fbytes.size(), exp_flen.pop_front());
    end
  endfunction

  // Monitor: FRAM device behaviour on SPI plus read-data / error scoreboard.
  always @(negedge clk) begin
    int t;
    logic [15:0] a;
    if (prev_csn && !o_spi_csn) begin
      frames_seen++;
      fbits = 0;
      fbytes.delete();
    end
    if (!o_spi_csn && o_spi_sck && !prev_sck) begin
      sh = {sh[6:0], o_spi_mosi};
      fbits++;
      if (fbits % 8 == 0) begin
        fbytes.push_back(sh);
        on_byte(sh);
      end
    end
    if (!o_spi_csn && !o_spi_sck && prev_sck && fbits >= 24 && fbytes[0] == 8'h03) begin
      t = fbits - 24;
      a = {fbytes[1], fbytes[2]} + 16'(t / 8);
      i_spi_miso = dev_mem[a][7 - (t % 8)];
    end
    if (!prev_csn && o_spi_csn) on_frame_end();
    prev_csn = o_spi_csn;
    prev_sck = o_spi_sck;
    if (o_fram_rd_dv) begin
      rd_seen++;
      if (!quiet) begin
        if (exp_rd.size() == 0) chk("rd_extra", {24'h0, om_fram_rdata}, 32'hffff_ffff);
        else                    chk("rd_data", {24'h0, om_fram_rdata}, {24'h0, exp_rd.pop_front()});
      end
    end
    if (o_fram_err) err_seen++;
  end

  task automatic wait_rdy(input int budget);
    int n = 0;
    while (!o_fram_rdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!o_fram_rdy) chk("rdy_timeout", 0, 1);
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] len);
    wait_rdy(20000);
    i_fram_rden = rd;
    i_fram_wren = wr;
    im_fram_addr = addr;
    im_fram_wr_len = len;
    @(negedge clk);
    i_fram_rden = 1'b0;
    i_fram_wren = 1'b0;
    if (rd ^ wr) chk("rdy_fall", o_fram_rdy, 0);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] len);
    int e0, f0;
    if (len != 0) begin
      exp_mosi.push_back(8'h03);
      exp_mosi.push_back(addr[15:8]);
      exp_mosi.push_back(addr[7:0]);
      for (int i = 0; i < int'(len); i++) begin
        exp_mosi.push_back(8'h00);
        exp_rd.push_back(ref_mem[addr + 16'(i)]);
      end
      exp_flen.push_back(int'(len) + 3);
    end
    e0 = err_seen;
    f0 = frames_seen;
    issue(1'b1, 1'b0, addr, len);
    wait_rdy(20000);
    repeat (3) @(negedge clk);
    chk("rd_err", err_seen - e0, 0);
    chk("rd_frames", frames_seen - f0, (len != 0) ? 1 : 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] len);
    bit hit, ok;
    int e0, f0;
    hit = (int'(len) <= WBUF) ? prot_hit(addr, int'(len)) : 1'b0;
    ok = (len != 0) && (int'(len) <= WBUF) && !hit;
    if (ok) begin
      exp_mosi.push_back(8'h06);
      exp_flen.push_back(1);
      exp_mosi.push_back(8'h02);
      exp_mosi.push_back(addr[15:8]);
      exp_mosi.push_back(addr[7:0]);
      for (int i = 0; i < int'(len); i++) begin
        exp_mosi.push_back(wq[i]);
        ref_mem[addr + 16'(i)] = wq[i];
      end
      exp_flen.push_back(int'(len) + 3);
    end
    e0 = err_seen;
    f0 = frames_seen;
    issue(1'b0, 1'b1, addr, len);
    if (len != 0 && int'(len) <= WBUF) begin
      for (int i = 0; i < int'(len); i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i_fram_wr_dv = 1'b1;
        im_fram_wdata = wq[i];
        @(negedge clk);
        i_fram_wr_dv = 1'b0;
      end
    end
    wait_rdy(20000);
    repeat (3) @(negedge clk);
    chk("wr_err", err_seen - e0, ((int'(len) > WBUF) || hit) ? 1 : 0);
    chk("wr_frames", frames_seen - f0, ok ? 2 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int e0, f0, r0, n;
    logic [15:0] a, l;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_csn", o_spi_csn, 1);
    chk("rst_sck", o_spi_sck, 0);
    chk("rst_mosi", o_spi_mosi, 0);
    chk("rst_rdy", o_fram_rdy, 1);
    chk("rst_rd_dv", o_fram_rd_dv, 0);
    chk("rst_rdata", om_fram_rdata, 0);
    chk("rst_err", o_fram_err, 0);
    rst = 1'b0;
    @(negedge clk);

    dev_mem[16'h1234] = 8'hA5; dev_mem[16'h1235] = 8'h5A; dev_mem[16'h1236] = 8'hFF;
    ref_mem[16'h1234] = 8'hA5; ref_mem[16'h1235] = 8'h5A; ref_mem[16'h1236] = 8'hFF;
    do_read(16'h1234, 16'd3);
    chk("rdy_after_read", o_fram_rdy, 1);

    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    do_write(16'h0200, 16'd2);
    do_read(16'h0200, 16'd2);

    e0 = err_seen;
    f0 = frames_seen;
    i_fram_rden = 1'b1;
    i_fram_wren = 1'b1;
    @(negedge clk);
    chk("both_err", o_fram_err, 1);
    chk("both_rdy", o_fram_rdy, 1);
    chk("both_csn", o_spi_csn, 1);
    i_fram_rden = 1'b0;
    i_fram_wren = 1'b0;
    @(negedge clk);
    chk("both_err_one_cycle", o_fram_err, 0);
    repeat (10) @(negedge clk);
    chk("both_err_count", err_seen - e0, 1);
    chk("both_no_frame", frames_seen - f0, 0);

    wq.delete();
    do_write(16'h0300, 16'd65);

    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    do_write(16'h00F0, 16'd4);
    do_read(16'h00F0, 16'd4);

    do_read(16'hFFFF, 16'd2);

    f0 = frames_seen;
    issue(1'b1, 1'b0, 16'h5555, 16'd0);
    @(negedge clk);
    chk("len0_rdy_back", o_fram_rdy, 1);
    repeat (5) @(negedge clk);
    chk("len0_no_frame", frames_seen - f0, 0);

    quiet = 1'b1;
    r0 = rd_seen;
    issue(1'b1, 1'b0, 16'h4000, 16'd4);
    n = 0;
    while (rd_seen == r0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_first_byte", rd_seen - r0, 1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_csn", o_spi_csn, 1);
    chk("midrst_sck", o_spi_sck, 0);
    chk("midrst_rdy", o_fram_rdy, 1);
    rst = 1'b0;
    r0 = rd_seen;
    f0 = frames_seen;
    repeat (150) @(negedge clk);
    chk("midrst_no_rd_dv", rd_seen - r0, 0);
    chk("midrst_no_frame", frames_seen - f0, 0);
    quiet = 1'b0;

    for (int it = 0; it < 20; it++) begin
      a = 16'($urandom);
      l = 16'($urandom_range(1, 12));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < int'(l); i++) wq.push_back(8'($urandom));
        do_write(a, l);
        do_read(a, l);
      end else begin
        do_read(a, l);
      end
    end

    chk("end_mosi_queue", exp_mosi.size(), 0);
    chk("end_flen_queue", exp_flen.size(), 0);
    chk("end_rd_queue", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
